// File: rtl/alu_pkg.sv
// Shared ALU op codes, RV32 opcodes, skid occupancy states and the issue payload
// used by the alu_issue slice.
package alu_pkg;

    localparam int XLEN = 32;

    localparam logic [7:0] ALU_NOP = 8'h00;
    localparam logic [7:0] ALU_ADD = 8'h11;
    localparam logic [7:0] ALU_SUB = 8'h12;
    localparam logic [7:0] ALU_MUL = 8'h13;
    localparam logic [7:0] ALU_DIV = 8'h14;
    localparam logic [7:0] ALU_MOD = 8'h15;
    localparam logic [7:0] ALU_AND = 8'h21;
    localparam logic [7:0] ALU_OR  = 8'h22;
    localparam logic [7:0] ALU_XOR = 8'h23;
    localparam logic [7:0] ALU_INV = 8'h24;
    localparam logic [7:0] ALU_SLT = 8'h31;
    localparam logic [7:0] ALU_SLL = 8'h33;
    localparam logic [7:0] ALU_SRL = 8'h34;
    localparam logic [7:0] ALU_SRA = 8'h35;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;

    typedef enum logic [1:0] {
        OCC_EMPTY,
        OCC_BUSY,
        OCC_FULL
    } occ_state_t;

    typedef struct packed {
        logic [7:0]      alu_op;
        logic [XLEN-1:0] a;
        logic [XLEN-1:0] b;
        logic [4:0]      rd;
        logic            illegal;
    } issue_entry_t;

endpackage

// File: rtl/alu_issue_decode.sv
// Combinational RV32 OP / OP-IMM decode into ALU op code and operand-B selects.
// M-extension ops are decoded only when ALU_ISSUE_RV32M_EN is defined.
module alu_issue_decode
    import alu_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output logic [7:0] alu_op,
    output logic       imm_sel,
    output logic       shamt_sel,
    output logic       illegal
);

    logic [7:0] op;
    logic       is_imm;
    logic       is_shamt;

    always_comb begin
        op       = ALU_NOP;
        is_imm   = 1'b0;
        is_shamt = 1'b0;
        case (opcode)
            OPC_OP: begin
                case (funct7)
                    7'b0000000: begin
                        case (funct3)
                            3'b000:  op = ALU_ADD;
                            3'b001:  op = ALU_SLL;
                            3'b010:  op = ALU_SLT;
                            3'b100:  op = ALU_XOR;
                            3'b101:  op = ALU_SRL;
                            3'b110:  op = ALU_OR;
                            3'b111:  op = ALU_AND;
                            default: op = ALU_NOP;
                        endcase
                    end
                    7'b0100000: begin
                        case (funct3)
                            3'b000:  op = ALU_SUB;
                            3'b101:  op = ALU_SRA;
                            default: op = ALU_NOP;
                        endcase
                    end
`ifdef ALU_ISSUE_RV32M_EN
                    7'b0000001: begin
                        case (funct3)
                            3'b000:  op = ALU_MUL;
                            3'b100:  op = ALU_DIV;
                            3'b110:  op = ALU_MOD;
                            default: op = ALU_NOP;
                        endcase
                    end
`endif
                    default: op = ALU_NOP;
                endcase
            end
            OPC_OP_IMM: begin
                is_imm = 1'b1;
                case (funct3)
                    3'b000: op = ALU_ADD;
                    3'b010: op = ALU_SLT;
                    3'b100: op = ALU_XOR;
                    3'b110: op = ALU_OR;
                    3'b111: op = ALU_AND;
                    3'b001: begin
                        if (funct7 == 7'b0000000) begin
                            op       = ALU_SLL;
                            is_shamt = 1'b1;
                        end
                    end
                    3'b101: begin
                        is_shamt = 1'b1;
                        if (funct7 == 7'b0000000)
                            op = ALU_SRL;
                        else if (funct7 == 7'b0100000)
                            op = ALU_SRA;
                    end
                    default: op = ALU_NOP;
                endcase
            end
            default: op = ALU_NOP;
        endcase
    end

    // No legal encoding ever maps to NOP, so NOP doubles as the illegal marker.
    assign illegal   = (op == ALU_NOP);
    assign alu_op    = op;
    assign imm_sel   = is_imm & ~illegal;
    assign shamt_sel = is_shamt & ~illegal;

endmodule

// File: rtl/alu_issue.sv
// Issue stage: decode + operand select feeding a registered 2-entry skid buffer
// towards the ALU. Build option: ALU_ISSUE_RV32M_EN enables MUL/DIV/REM decode.
//
// state     | meaning
// OCC_EMPTY | nothing held; o_valid=0, o_ready=1
// OCC_BUSY  | output register full, skid empty; o_valid=1, o_ready=1
// OCC_FULL  | output and skid full; o_valid=1, o_ready=0
module alu_issue
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_flush,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [31:0]           i_instr,
    input  logic [DATA_WIDTH-1:0] i_rs1_data,
    input  logic [DATA_WIDTH-1:0] i_rs2_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [7:0]            o_alu_op,
    output logic [DATA_WIDTH-1:0] o_a,
    output logic [DATA_WIDTH-1:0] o_b,
    output logic [4:0]            o_rd,
    output logic                  o_illegal
);

    occ_state_t   state;
    issue_entry_t out_q;
    issue_entry_t skid_q;
    issue_entry_t new_entry;

    logic [7:0] dec_op;
    logic       dec_imm_sel;
    logic       dec_shamt_sel;
    logic       dec_illegal;
    logic       accept;
    logic       issue;

    // Register indices are consumed by the register file upstream.
    logic unused_rs_idx;
    assign unused_rs_idx = ^i_instr[19:15];

    alu_issue_decode u_decode (
        .opcode    (i_instr[6:0]),
        .funct3    (i_instr[14:12]),
        .funct7    (i_instr[31:25]),
        .alu_op    (dec_op),
        .imm_sel   (dec_imm_sel),
        .shamt_sel (dec_shamt_sel),
        .illegal   (dec_illegal)
    );

    always_comb begin
        new_entry.alu_op  = dec_op;
        new_entry.rd      = i_instr[11:7];
        new_entry.illegal = dec_illegal;
        new_entry.a       = '0;
        new_entry.b       = '0;
        if (!dec_illegal) begin
            new_entry.a = i_rs1_data;
            if (dec_shamt_sel)
                new_entry.b = {27'b0, i_instr[24:20]};
            else if (dec_imm_sel)
                new_entry.b = {{20{i_instr[31]}}, i_instr[31:20]};
            else
                new_entry.b = i_rs2_data;
        end
    end

    assign accept = i_valid & o_ready;
    assign issue  = o_valid & i_ready;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state   <= OCC_EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
            out_q   <= '0;
            skid_q  <= '0;
        end else if (i_flush) begin
            state   <= OCC_EMPTY;
            o_valid <= 1'b0;
            o_ready <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (accept) begin
                        out_q   <= new_entry;
                        o_valid <= 1'b1;
                        state   <= OCC_BUSY;
                    end
                end
                OCC_BUSY: begin
                    if (accept && issue) begin
                        out_q <= new_entry;
                    end else if (accept) begin
                        skid_q  <= new_entry;
                        o_ready <= 1'b0;
                        state   <= OCC_FULL;
                    end else if (issue) begin
                        o_valid <= 1'b0;
                        state   <= OCC_EMPTY;
                    end
                end
                OCC_FULL: begin
                    if (issue) begin
                        out_q   <= skid_q;
                        o_ready <= 1'b1;
                        state   <= OCC_BUSY;
                    end
                end
                default: begin
                    state   <= OCC_EMPTY;
                    o_valid <= 1'b0;
                    o_ready <= 1'b1;
                end
            endcase
        end
    end

    assign o_alu_op  = out_q.alu_op;
    assign o_a       = out_q.a;
    assign o_b       = out_q.b;
    assign o_rd      = out_q.rd;
    assign o_illegal = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Directed self-checking bench for alu_issue: decode vectors, backpressure,
// flush and reset behaviour of the skid buffer.
module tb_alu_issue;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_flush;
    logic        i_valid;
    logic        o_ready;
    logic [31:0] i_instr;
    logic [31:0] i_rs1_data;
    logic [31:0] i_rs2_data;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_alu_op;
    logic [31:0] o_a;
    logic [31:0] o_b;
    logic [4:0]  o_rd;
    logic        o_illegal;

    int tests = 0;
    int fails = 0;

    always #5 i_clk = ~i_clk;

    alu_issue #(.DATA_WIDTH(32)) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_flush    (i_flush),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_instr    (i_instr),
        .i_rs1_data (i_rs1_data),
        .i_rs2_data (i_rs2_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_alu_op   (o_alu_op),
        .o_a        (o_a),
        .o_b        (o_b),
        .o_rd       (o_rd),
        .o_illegal  (o_illegal)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One instruction through an idle stage with i_ready held high.
    task automatic issue_one(input string tag, input logic [31:0] instr,
                             input logic [31:0] rs1, input logic [31:0] rs2,
                             input logic [7:0] op, input logic [31:0] a,
                             input logic [31:0] b, input logic [4:0] rd,
                             input logic ill);
        @(negedge i_clk);
        i_valid    = 1'b1;
        i_instr    = instr;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
        i_ready    = 1'b1;
        @(negedge i_clk);
        i_valid = 1'b0;
        chk({tag, ".valid"}, {31'b0, o_valid}, 32'd1);
        chk({tag, ".op"}, {24'b0, o_alu_op}, {24'b0, op});
        chk({tag, ".a"}, o_a, a);
        chk({tag, ".b"}, o_b, b);
        chk({tag, ".rd"}, {27'b0, o_rd}, {27'b0, rd});
        chk({tag, ".illegal"}, {31'b0, o_illegal}, {31'b0, ill});
        @(negedge i_clk);
        chk({tag, ".once"}, {31'b0, o_valid}, 32'd0);
    endtask

    task automatic offer(input logic [31:0] instr, input logic [31:0] rs1, input logic [31:0] rs2);
        i_valid    = 1'b1;
        i_instr    = instr;
        i_rs1_data = rs1;
        i_rs2_data = rs2;
    endtask

    initial begin
        i_rst      = 1'b1;
        i_flush    = 1'b0;
        i_valid    = 1'b0;
        i_instr    = '0;
        i_rs1_data = '0;
        i_rs2_data = '0;
        i_ready    = 1'b0;
        repeat (2) @(negedge i_clk);
        chk("rst.valid", {31'b0, o_valid}, 32'd0);
        chk("rst.ready", {31'b0, o_ready}, 32'd1);
        chk("rst.op", {24'b0, o_alu_op}, 32'd0);
        chk("rst.a", o_a, 32'd0);
        chk("rst.b", o_b, 32'd0);
        chk("rst.rd", {27'b0, o_rd}, 32'd0);
        chk("rst.illegal", {31'b0, o_illegal}, 32'd0);
        i_rst = 1'b0;

        issue_one("add",   32'h002081B3, 32'd5,         32'd7,  8'h11, 32'd5,         32'd7,         5'd3, 1'b0);
        issue_one("addi",  32'hFFF00093, 32'h0000_1234, 32'd9,  8'h11, 32'h0000_1234, 32'hFFFF_FFFF, 5'd1, 1'b0);
        issue_one("srai",  32'h40435293, 32'h8000_0000, 32'd99, 8'h35, 32'h8000_0000, 32'd4,         5'd5, 1'b0);
        issue_one("sub",   32'h402081B3, 32'd10,        32'd3,  8'h12, 32'd10,        32'd3,         5'd3, 1'b0);
        issue_one("xor",   32'h0020C1B3, 32'hF0,        32'h0F, 8'h23, 32'hF0,        32'h0F,        5'd3, 1'b0);
        issue_one("slli",  32'h00431293, 32'd1,         32'd77, 8'h33, 32'd1,         32'd4,         5'd5, 1'b0);
        issue_one("andi",  32'h7F00F113, 32'hFFFF,      32'd0,  8'h21, 32'hFFFF,      32'h7F0,       5'd2, 1'b0);
        issue_one("sltu",  32'h0020B1B3, 32'd5,         32'd7,  8'h00, 32'd0,         32'd0,         5'd3, 1'b1);
        issue_one("load",  32'h0000A183, 32'd5,         32'd7,  8'h00, 32'd0,         32'd0,         5'd3, 1'b1);
        issue_one("or_f7", 32'h4020E1B3, 32'd5,         32'd7,  8'h00, 32'd0,         32'd0,         5'd3, 1'b1);
        issue_one("srli7", 32'h02435293, 32'd5,         32'd7,  8'h00, 32'd0,         32'd0,         5'd5, 1'b1);
        issue_one("mulh",  32'h022091B3, 32'd5,         32'd7,  8'h00, 32'd0,         32'd0,         5'd3, 1'b1);
`ifdef ALU_ISSUE_RV32M_EN
        issue_one("mul",   32'h022081B3, 32'd6,         32'd7,  8'h13, 32'd6,         32'd7,         5'd3, 1'b0);
        issue_one("div",   32'h0220C1B3, 32'd42,        32'd6,  8'h14, 32'd42,        32'd6,         5'd3, 1'b0);
`else
        issue_one("mul",   32'h022081B3, 32'd6,         32'd7,  8'h00, 32'd0,         32'd0,         5'd3, 1'b1);
        issue_one("div",   32'h0220C1B3, 32'd42,        32'd6,  8'h00, 32'd0,         32'd0,         5'd3, 1'b1);
`endif

        // Backpressure: ADD rd3, ADDI rd1, SRAI rd5 offered back to back.
        @(negedge i_clk);
        i_ready = 1'b0;
        offer(32'h002081B3, 32'd5, 32'd7);
        @(negedge i_clk);
        chk("bp.ready1", {31'b0, o_ready}, 32'd1);
        offer(32'hFFF00093, 32'd8, 32'd0);
        @(negedge i_clk);
        chk("bp.ready2", {31'b0, o_ready}, 32'd0);
        chk("bp.rd_i1", {27'b0, o_rd}, 32'd3);
        offer(32'h40435293, 32'd64, 32'd0);
        @(negedge i_clk);
        chk("bp.hold_rd", {27'b0, o_rd}, 32'd3);
        chk("bp.hold_op", {24'b0, o_alu_op}, 32'h11);
        chk("bp.hold_ready", {31'b0, o_ready}, 32'd0);
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("bp.i2_rd", {27'b0, o_rd}, 32'd1);
        chk("bp.i2_b", o_b, 32'hFFFF_FFFF);
        chk("bp.i2_ready", {31'b0, o_ready}, 32'd1);
        @(negedge i_clk);
        i_valid = 1'b0;
        chk("bp.i3_rd", {27'b0, o_rd}, 32'd5);
        chk("bp.i3_op", {24'b0, o_alu_op}, 32'h35);
        chk("bp.i3_a", o_a, 32'd64);
        @(negedge i_clk);
        chk("bp.empty", {31'b0, o_valid}, 32'd0);
        chk("bp.ready_end", {31'b0, o_ready}, 32'd1);

        // Flush while FULL, with a same-cycle input offered.
        i_ready = 1'b0;
        offer(32'h002081B3, 32'd5, 32'd7);
        @(negedge i_clk);
        offer(32'hFFF00093, 32'd8, 32'd0);
        @(negedge i_clk);
        chk("fl.full", {31'b0, o_ready}, 32'd0);
        offer(32'h40435293, 32'd64, 32'd0);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("fl.valid", {31'b0, o_valid}, 32'd0);
        chk("fl.ready", {31'b0, o_ready}, 32'd1);
        i_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge i_clk);
            chk("fl.no_issue", {31'b0, o_valid}, 32'd0);
        end

        // Flush while BUSY, with a same-cycle input that would be accepted.
        i_ready = 1'b0;
        offer(32'h002081B3, 32'd5, 32'd7);
        @(negedge i_clk);
        offer(32'h40435293, 32'd64, 32'd0);
        i_flush = 1'b1;
        @(negedge i_clk);
        i_flush = 1'b0;
        i_valid = 1'b0;
        chk("flb.valid", {31'b0, o_valid}, 32'd0);
        chk("flb.ready", {31'b0, o_ready}, 32'd1);
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("flb.no_issue", {31'b0, o_valid}, 32'd0);
        issue_one("post_flush", 32'h0020C1B3, 32'd3, 32'd12, 8'h23, 32'd3, 32'd12, 5'd3, 1'b0);

        // Reset while FULL discards both entries.
        i_ready = 1'b0;
        offer(32'h002081B3, 32'd5, 32'd7);
        @(negedge i_clk);
        offer(32'hFFF00093, 32'd8, 32'd0);
        @(negedge i_clk);
        i_valid = 1'b0;
        i_rst   = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        chk("mrst.valid", {31'b0, o_valid}, 32'd0);
        chk("mrst.ready", {31'b0, o_ready}, 32'd1);
        chk("mrst.op", {24'b0, o_alu_op}, 32'd0);
        chk("mrst.rd", {27'b0, o_rd}, 32'd0);
        i_ready = 1'b1;
        @(negedge i_clk);
        chk("mrst.no_issue", {31'b0, o_valid}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
